// File: rtl/minmax_pkg.sv
// minmax_pkg: shared constants and helpers for the min/max tracker.
// Empty-state values are derived from the sample width so every lane
// and any consumer agree on what "no samples yet" looks like.
package minmax_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // All-ones in the low w bits: the running minimum before any sample.
  function automatic logic [MAX_WIDTH-1:0] min_init(input int unsigned w);
    logic [MAX_WIDTH-1:0] all_ones;
    all_ones = '1;
    return all_ones >> (MAX_WIDTH - w);
  endfunction

  // Zero: the running maximum before any sample.
  function automatic logic [MAX_WIDTH-1:0] max_init(input int unsigned w);
    return (w == 0) ? '0 : '0;
  endfunction

  // LSB position of lane `lane` in a packed bus of w-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/minmax_if.sv
// minmax_if: sample bus into the tracker and the per-lane statistics out.
// master = sample-capture side, slave = tracker side.
interface minmax_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned COUNT_W = 8
);
  logic                        in_valid;
  logic [NUM_CH-1:0]           in_clear;
  logic [NUM_CH*WIDTH-1:0]     in_data;
  logic [WIDTH-1:0]            range_thresh;
  logic [NUM_CH*WIDTH-1:0]     min_out;
  logic [NUM_CH*WIDTH-1:0]     max_out;
  logic [NUM_CH*WIDTH-1:0]     range_out;
  logic [NUM_CH*COUNT_W-1:0]   count_out;
  logic [NUM_CH-1:0]           seen_out;
  logic                        upd_out;
  logic [NUM_CH-1:0]           alarm_out;

  modport master (
    output in_valid, in_clear, in_data, range_thresh,
    input  min_out, max_out, range_out, count_out, seen_out, upd_out, alarm_out
  );

  modport slave (
    input  in_valid, in_clear, in_data, range_thresh,
    output min_out, max_out, range_out, count_out, seen_out, upd_out, alarm_out
  );
endinterface

// File: rtl/minmax_lane.sv
// minmax_lane: one channel of running min/max/range/count tracking.
// Optional sticky range alarm compiled in with MINMAX_RANGE_ALARM_EN.
module minmax_lane
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid,
  input  logic               clear,
  input  logic [WIDTH-1:0]   sample,
  input  logic [WIDTH-1:0]   thresh,
  output logic [WIDTH-1:0]   min_q,
  output logic [WIDTH-1:0]   max_q,
  output logic [WIDTH-1:0]   range_q,
  output logic [COUNT_W-1:0] count_q,
  output logic               seen_q,
  output logic               alarm_q
);

  localparam logic [WIDTH-1:0] MIN_INIT = WIDTH'(min_init(WIDTH));
  localparam logic [WIDTH-1:0] MAX_INIT = WIDTH'(max_init(WIDTH));

  logic [WIDTH-1:0]   base_min, base_max;
  logic [COUNT_W-1:0] base_cnt;
  logic [WIDTH-1:0]   min_d, max_d, range_d;
  logic [COUNT_W-1:0] cnt_d;
  logic               seen_d;

  // Next state: clear first collapses history to empty, then a valid
  // sample folds into that base, so clear+valid loads s as first sample.
  always_comb begin
    base_min = clear ? MIN_INIT : min_q;
    base_max = clear ? MAX_INIT : max_q;
    base_cnt = clear ? '0 : count_q;
    min_d    = base_min;
    max_d    = base_max;
    cnt_d    = base_cnt;
    range_d  = clear ? '0 : range_q;
    seen_d   = clear ? 1'b0 : seen_q;
    if (valid) begin
      if (sample < base_min) min_d = sample;
      if (sample > base_max) max_d = sample;
      range_d = max_d - min_d;
      if (base_cnt != '1) cnt_d = base_cnt + COUNT_W'(1);
      seen_d  = 1'b1;
    end
  end

  // Lane state registers; reset returns to the empty state.
  always_ff @(posedge clock) begin
    if (reset) begin
      min_q   <= MIN_INIT;
      max_q   <= MAX_INIT;
      range_q <= '0;
      count_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      range_q <= range_d;
      count_q <= cnt_d;
      seen_q  <= seen_d;
    end
  end

`ifdef MINMAX_RANGE_ALARM_EN
  logic alarm_d;

  // Sticky alarm: cleared with the lane, set when the new range exceeds thresh.
  always_comb begin
    alarm_d = (clear ? 1'b0 : alarm_q) | (valid && (range_d > thresh));
  end

  // Alarm flop.
  always_ff @(posedge clock) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign alarm_q       = 1'b0;
`endif

endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: NUM_CH parallel running min/max/range/count trackers.
// Optional macro: MINMAX_RANGE_ALARM_EN enables the sticky per-lane range alarm.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic     clock,
  input  logic     reset,
  minmax_if.slave  bus
);

  logic [NUM_CH*WIDTH-1:0]   min_all, max_all, range_all;
  logic [NUM_CH*COUNT_W-1:0] count_all;
  logic [NUM_CH-1:0]         seen_all, alarm_all;
  logic                      upd_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    minmax_lane #(
      .WIDTH   (WIDTH),
      .COUNT_W (COUNT_W)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .valid   (bus.in_valid),
      .clear   (bus.in_clear[i]),
      .sample  (bus.in_data[lane_lsb(i, WIDTH) +: WIDTH]),
      .thresh  (bus.range_thresh),
      .min_q   (min_all[lane_lsb(i, WIDTH) +: WIDTH]),
      .max_q   (max_all[lane_lsb(i, WIDTH) +: WIDTH]),
      .range_q (range_all[lane_lsb(i, WIDTH) +: WIDTH]),
      .count_q (count_all[lane_lsb(i, COUNT_W) +: COUNT_W]),
      .seen_q  (seen_all[i]),
      .alarm_q (alarm_all[i])
    );
  end

  // Update pulse: registered in_valid, aligned with the lane outputs.
  always_ff @(posedge clock) begin
    if (reset) upd_q <= 1'b0;
    else       upd_q <= bus.in_valid;
  end

  assign bus.min_out   = min_all;
  assign bus.max_out   = max_all;
  assign bus.range_out = range_all;
  assign bus.count_out = count_all;
  assign bus.seen_out  = seen_all;
  assign bus.alarm_out = alarm_all;
  assign bus.upd_out   = upd_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: table vectors, directed corner sequences and random
// stimulus against a sample-history reference model. WIDTH=4, NUM_CH=2.
module tb_minmax_tracker;

  localparam int unsigned W  = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned CMAX = (1 << CW) - 1;

`ifdef MINMAX_RANGE_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  minmax_if #(.WIDTH(W), .NUM_CH(NC), .COUNT_W(CW)) bus ();

  minmax_tracker #(.WIDTH(W), .NUM_CH(NC), .COUNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw sample history per lane since last clear.
  int     hist [NC][$];
  int     m_cnt [NC];
  bit     m_alarm [NC];
  bit     m_upd;

  function automatic int h_min(input int l);
    int r = (1 << W) - 1;
    foreach (hist[l][k]) if (hist[l][k] < r) r = hist[l][k];
    return r;
  endfunction

  function automatic int h_max(input int l);
    int r = 0;
    foreach (hist[l][k]) if (hist[l][k] > r) r = hist[l][k];
    return r;
  endfunction

  function automatic int h_range(input int l);
    return (hist[l].size() == 0) ? 0 : h_max(l) - h_min(l);
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int l = 0; l < NC; l++) begin
        hist[l].delete(); m_cnt[l] = 0; m_alarm[l] = 0;
      end
      m_upd = 0;
    end else begin
      for (int l = 0; l < NC; l++) begin
        if (bus.in_clear[l]) begin
          hist[l].delete(); m_cnt[l] = 0; m_alarm[l] = 0;
        end
        if (bus.in_valid) begin
          hist[l].push_back(int'(bus.in_data[l*W +: W]));
          if (m_cnt[l] < CMAX) m_cnt[l]++;
          if (ALARM_ON && h_range(l) > int'(bus.range_thresh)) m_alarm[l] = 1;
        end
      end
      m_upd = bus.in_valid;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    for (int l = 0; l < NC; l++) begin
      chk($sformatf("%s min%0d", tag, l),   32'(bus.min_out[l*W +: W]),    32'(h_min(l)));
      chk($sformatf("%s max%0d", tag, l),   32'(bus.max_out[l*W +: W]),    32'(h_max(l)));
      chk($sformatf("%s range%0d", tag, l), 32'(bus.range_out[l*W +: W]),  32'(h_range(l)));
      chk($sformatf("%s count%0d", tag, l), 32'(bus.count_out[l*CW +: CW]), 32'(m_cnt[l]));
      chk($sformatf("%s seen%0d", tag, l),  32'(bus.seen_out[l]),          32'(hist[l].size() != 0));
      chk($sformatf("%s alarm%0d", tag, l), 32'(bus.alarm_out[l]),         32'(m_alarm[l]));
    end
    chk($sformatf("%s upd", tag), 32'(bus.upd_out), 32'(m_upd));
  endtask

  // Apply inputs, take one rising edge, advance model, sample 1 time unit later.
  task automatic step(input logic v, input logic [NC-1:0] clr, input int d0, input int d1);
    bus.in_valid = v;
    bus.in_clear = clr;
    bus.in_data  = {W'(d1), W'(d0)};
    @(posedge clock);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [NC-1:0] clr;
    int            d0, d1;
    int            mn0, mx0, rg0, c0;
    int            mn1, mx1, rg1, c1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bus.in_valid = 0; bus.in_clear = '0; bus.in_data = '0; bus.range_thresh = 4'd15;

    tbl[0] = '{1, 2'b00, 5, 1,  5, 5, 0, 1,   1,  1,  0, 1};
    tbl[1] = '{1, 2'b00, 2, 14, 2, 5, 3, 2,   1, 14, 13, 2};
    tbl[2] = '{1, 2'b00, 9, 7,  2, 9, 7, 3,   1, 14, 13, 3};
    tbl[3] = '{1, 2'b01, 6, 3,  6, 6, 0, 1,   1, 14, 13, 4};
    tbl[4] = '{0, 2'b10, 0, 0,  6, 6, 0, 1,  15,  0,  0, 0};
    tbl[5] = '{0, 2'b00, 9, 9,  6, 6, 0, 1,  15,  0,  0, 0};

    // Reset state.
    reset = 1;
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    chk("reset min_out",   32'(bus.min_out),   32'h0000_00FF);
    chk("reset max_out",   32'(bus.max_out),   32'h0);
    chk("reset range_out", 32'(bus.range_out), 32'h0);
    chk("reset count_out", 32'(bus.count_out), 32'h0);
    chk("reset seen_out",  32'(bus.seen_out),  32'h0);
    chk("reset upd_out",   32'(bus.upd_out),   32'h0);
    chk("reset alarm_out", 32'(bus.alarm_out), 32'h0);
    reset = 0;

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].clr, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d min0", i),   32'(bus.min_out[0 +: W]),   32'(tbl[i].mn0));
      chk($sformatf("tbl%0d max0", i),   32'(bus.max_out[0 +: W]),   32'(tbl[i].mx0));
      chk($sformatf("tbl%0d range0", i), 32'(bus.range_out[0 +: W]), 32'(tbl[i].rg0));
      chk($sformatf("tbl%0d count0", i), 32'(bus.count_out[0 +: CW]), 32'(tbl[i].c0));
      chk($sformatf("tbl%0d min1", i),   32'(bus.min_out[W +: W]),   32'(tbl[i].mn1));
      chk($sformatf("tbl%0d max1", i),   32'(bus.max_out[W +: W]),   32'(tbl[i].mx1));
      chk($sformatf("tbl%0d range1", i), 32'(bus.range_out[W +: W]), 32'(tbl[i].rg1));
      chk($sformatf("tbl%0d count1", i), 32'(bus.count_out[CW +: CW]), 32'(tbl[i].c1));
      chk($sformatf("tbl%0d upd", i),    32'(bus.upd_out),           32'(tbl[i].v));
    end

    // Alarm: thresh 4, samples 3 then 8 give range 5 (> 4), sticky until clear.
    bus.range_thresh = 4'd4;
    step(0, 2'b11, 0, 0);
    step(1, 2'b00, 3, 3);
    chk("alarm after 3", 32'(bus.alarm_out[0]), 32'h0);
    step(1, 2'b00, 8, 3);
    chk("alarm set range5", 32'(bus.alarm_out[0]), 32'(ALARM_ON));
    chk("alarm range5 val", 32'(bus.range_out[0 +: W]), 32'd5);
    step(1, 2'b00, 5, 3);
    chk("alarm sticky", 32'(bus.alarm_out[0]), 32'(ALARM_ON));
    chk("alarm lane1 quiet", 32'(bus.alarm_out[1]), 32'h0);
    step(1, 2'b01, 15, 3);
    chk("alarm clr+load", 32'(bus.alarm_out[0]), 32'h0);
    chk("clr+load range", 32'(bus.range_out[0 +: W]), 32'h0);
    check_model("alarm");

    // Counter saturation with 300 samples.
    bus.range_thresh = 4'd15;
    step(0, 2'b11, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      step(1, 2'b00, $urandom_range(0, 15), $urandom_range(0, 15));
      if (k == 254 || k == 255 || k == 256 || k == 300) check_model($sformatf("sat%0d", k));
    end
    chk("sat count0", 32'(bus.count_out[0 +: CW]), 32'd255);
    chk("sat count1", 32'(bus.count_out[CW +: CW]), 32'd255);
    step(0, 2'b00, 0, 0);
    chk("sat hold", 32'(bus.count_out[0 +: CW]), 32'd255);

    // Reset mid-stream with valid and clear high.
    reset = 1;
    step(1, 2'b11, 9, 9);
    check_model("midreset");
    chk("midreset min_out", 32'(bus.min_out), 32'h0000_00FF);
    reset = 0;
    step(1, 2'b00, 7, 7);
    chk("post reset min0", 32'(bus.min_out[0 +: W]), 32'd7);
    chk("post reset max0", 32'(bus.max_out[0 +: W]), 32'd7);
    chk("post reset count0", 32'(bus.count_out[0 +: CW]), 32'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) bus.range_thresh = W'($urandom_range(0, 15));
      step(($urandom_range(0, 9) < 7),
           {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
           $urandom_range(0, 15), $urandom_range(0, 15));
      check_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/minmax_tracker.md
# minmax_tracker

Parametrised multi-channel running minimum/maximum tracker, generalising the 4-bit single-channel MinMax block. Each of NUM_CH lanes tracks min, max, range (max − min) and a saturating sample count of an unsigned WIDTH-bit stream since the last clear. It sits after the sample-capture stage and feeds the statistics/monitor logic. An optional sticky range alarm is compiled in by macro.

## Interface
- WIDTH, 4: sample width per channel, ≥2
- NUM_CH, 4: number of parallel channels, ≥1
- COUNT_W, 8: per-channel sample counter width
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  samples on in_data are accepted this cycle
- in_clear  in  NUM_CH  per-channel restart of tracking
- in_data  in  NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
- range_thresh  in  WIDTH  alarm threshold (ignored without macro)
- min_out  out  NUM_CH*WIDTH  registered running minimum per channel
- max_out  out  NUM_CH*WIDTH  registered running maximum per channel
- range_out  out  NUM_CH*WIDTH  registered max − min per channel
- count_out  out  NUM_CH*COUNT_W  samples since clear, saturating
- seen_out  out  NUM_CH  channel holds at least one sample
- upd_out  out  1  pulse: outputs reflect a new sample this cycle
- alarm_out  out  NUM_CH  sticky range-exceeded flag

## Operation
- Empty state per lane: min = all-ones, max = 0, range = 0, count = 0, seen = 0, alarm = 0.
- Valid sample s, lane not cleared: min ← min(min,s), max ← max(max,s), range ← new max − new min, count ← count+1 saturating at 2^COUNT_W−1, seen ← 1.
- First sample after empty: min = max = s, range = 0 (falls out of the rule above).
- Clear without valid: lane returns to empty state.
- Clear with valid same cycle: clear wins over old history; lane loaded with s as first sample (min=max=s, range 0, count 1, seen 1, alarm 0).
- Clear on lane i never affects lane j.
- No valid, no clear: all state holds.
- Comparisons unsigned; range is WIDTH bits, never negative since max ≥ min whenever seen=1; range forced 0 when seen=0.
- upd_out = registered in_valid.

## Timing
- Latency 1: sample accepted at edge N visible on all outputs after edge N (cycle N+1); range computed from the updated min/max, not the stale ones.
- Back-to-back valid every cycle supported; no backpressure.
- Reset dominates valid and clear; every output takes its empty value (min all-ones, others 0) after the reset edge.
- Reset asserted mid-stream: all history discarded, first valid after release starts fresh.
- Counter at saturation stays saturated; min/max still update.

## Configuration
- MINMAX_RANGE_ALARM_EN defined: alarm_out[i] set on the cycle where new range > range_thresh (strict), stays set until clear of lane i or reset; set and clear same cycle with qualifying sample: clear-then-load applies, range 0, alarm stays 0.
- Undefined: alarm_out tied 0, range_thresh unused, no alarm flops.

## Structure
- Shared package minmax_pkg: empty-state constants (MIN_INIT all-ones, MAX_INIT zero) as functions of WIDTH, lane-slice helper for packed buses.
- One sub-module minmax_lane: single-channel state, update/clear logic, counter and optional alarm; top instantiates NUM_CH lanes via generate and registers upd_out.

## Test plan
- Reset then WIDTH=4, NUM_CH=2: all outputs empty; min_out = 8'hFF, max_out = 0, seen_out = 0.
- Lane 0 samples 5, 2, 9 on consecutive cycles -> next cycles min 5/2/2, max 5/5/9, range 0/3/7, count 1/2/3.
- Clear lane 0 with valid sample 6 while lane 1 holds min 1 max 14 -> lane 0 min=max=6, range 0, count 1; lane 1 with sample 3 gets range 13, unaffected by clear.
- 300 valid samples with COUNT_W=8 -> count_out saturates at 255 and holds.
- Macro on, range_thresh=4, samples 3 then 8 -> alarm set (range 5) and holds through later samples until clear; macro off -> alarm_out stays 0.
- Reset asserted with valid and clear high mid-stream -> empty state next cycle; next valid 7 gives min=max=7, count 1.
